hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush controller driving the IF/ID and ID/EX pipeline registers from the consumer side.
//  - Watches the instruction leaving ID/EX (EX stage) and the one in ID.
//  - Inserts load-use stall bubbles and squashes wrong-path instructions on taken EX-resolved branches.
//  - Emits pc_write, if_id_write, if_id_flush and id_ex_flush; the flush makes ID/EX capture an all-zero control bundle.
// PARAMETERS
//  LOAD_STALL      1   bubble cycles per load-use hazard (1..7); >1 for slow data memory
//  BRANCH_EXTRA    0   extra full-flush cycles after taken-branch redirect (0..7)
//  CNT_W           32  width of performance counters
// PORTS
//  clk             in   1      rising-edge clock
//  reset_n         in   1      asynchronous, active-low reset
//  id_rs           in   5      rs field of instruction in ID
//  id_rt           in   5      rt field of instruction in ID
//  id_uses_rt      in   1      ID instruction reads rt as a source (R-type, sw, beq)
//  ex_mem_read     in   1      MemRead of instruction in EX (ID/EX output)
//  ex_rt           in   5      rt of instruction in EX (load destination)
//  ex_branch       in   1      Branch of instruction in EX
//  ex_branch_taken in   1      branch condition true (ALU zero), valid with ex_branch
//  pc_write        out  1      1 = PC may update this cycle
//  if_id_write     out  1      1 = IF/ID may capture this cycle
//  if_id_flush     out  1      1 = IF/ID loads a NOP
//  id_ex_flush     out  1      1 = ID/EX loads zero controls (bubble)
//  stall_cnt       out  CNT_W  load-use bubble cycles since reset
//  flush_cnt       out  CNT_W  taken-branch redirects since reset
// BEHAVIOUR
//  - FSM states: RUN, STALL, FLUSH. State and counters registered; outputs combinational from state+inputs.
//  - Reset (reset_n=0, immediate): state=RUN, rem=0, counters=0.
//    While reset_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
//  - hzd = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
//  - tkn = ex_branch & ex_branch_taken.
//  RUN, priority tkn over hzd (branch is older):
//  - tkn: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
//    If BRANCH_EXTRA>0, go FLUSH with rem=BRANCH_EXTRA; else stay RUN.
//  - hzd (no tkn): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
//    If LOAD_STALL>1, go STALL with rem=LOAD_STALL-1; else stay RUN.
//  - neither: pc_write=1, if_id_write=1, both flushes 0.
//  STALL:
//  - Same outputs as the hzd case regardless of inputs; rem decrements each cycle.
//  - Exits to RUN in the cycle rem reaches 1; the ID instruction then proceeds.
//  - Hazard is not re-evaluated in STALL (EX holds a bubble).
//  FLUSH:
//  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; rem decrements; RUN when rem hits 1.
//  Total bubble latency: load-use = LOAD_STALL cycles; taken branch = 2+BRANCH_EXTRA slots squashed.
//  Boundaries:
//  - rd/rt==0 never stalls.
//  - ex_branch_taken is ignored when ex_branch=0.
//  - Counters saturate at all-ones (no wrap).
//  - Reset mid-STALL/FLUSH aborts to RUN.
//  stall_cnt: +1 every cycle id_ex_flush=1 due to hzd/STALL. flush_cnt: +1 per tkn redirect in RUN.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//  - stall_cnt/flush_cnt implemented as above.
//  HAZARD_PERF_CNT_EN undefined:
//  - No counter flops; stall_cnt=flush_cnt=0 constant; ports retained.
//  - Stall/flush behaviour identical.
// TESTING
//  1 reset_n=0 mid-STALL (LOAD_STALL=3) -> outputs 0/0/1/1 immediately; after release RUN, counters=0.
//  2 ex_mem_read=1, ex_rt=8, id_rs=8 -> 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1.
//  3 ex_rt=0=id_rs with ex_mem_read=1 -> no stall; id_ex_flush=0.
//  4 id_rt=9=ex_rt with id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
//  5 tkn and hzd same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
//  6 LOAD_STALL=3, BRANCH_EXTRA=2 -> load-use gives 3 stall cycles; tkn gives 3 flush cycles, then RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the IF/ID and ID/EX registers.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_EXTRA = 0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       hzd;
    logic       tkn;

    assign hzd = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // The branch in EX is older than the load-use pair, so it wins.
    assign tkn = ex_branch && ex_branch_taken;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (tkn) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (BRANCH_EXTRA > 0) begin
                        state_d = ST_FLUSH;
                        rem_d   = 3'(BRANCH_EXTRA);
                    end
                end else if (hzd) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_STALL;
                        rem_d   = 3'(LOAD_STALL - 1);
                    end
                end
            end
            ST_STALL: begin
                // EX holds a bubble here, so the hazard is not re-evaluated.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                rem_d       = rem_q - 3'd1;
                if (rem_q <= 3'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                rem_d       = rem_q - 3'd1;
                if (rem_q <= 3'd1) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = 3'd0;
            end
        endcase

        // Hold both pipeline registers empty while reset is asserted.
        if (!reset_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             stall_slot;
    logic             flush_redirect;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_slot     = (state_q == ST_STALL) || ((state_q == ST_RUN) && !tkn && hzd);
    assign flush_redirect = (state_q == ST_RUN) && tkn;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_slot && !(&stall_cnt_q))     stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance (1-cycle stall, no extra flush)
// and a slow instance (3-cycle stall, 2 extra flush cycles, 2-bit saturating counters).
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch, ex_branch_taken;

    logic        a_pc, a_ifw, a_iff, a_idf;
    logic [31:0] a_stall, a_flush;
    logic        b_pc, b_ifw, b_iff, b_idf;
    logic [1:0]  b_stall, b_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl u_a (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_ctrl #(.LOAD_STALL(3), .BRANCH_EXTRA(2), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output bundles are {pc_write, if_id_write, if_id_flush, id_ex_flush}.
    task automatic check_a(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, a_pc, a_ifw, a_iff, a_idf}, {28'd0, exp});
    endtask

    task automatic check_b(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, b_pc, b_ifw, b_iff, b_idf}, {28'd0, exp});
    endtask

    function automatic logic [31:0] pc(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd5;
        ex_branch = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic load_use();
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #1;
        check_a("rst_out_a", 4'b0011);
        check_b("rst_out_b", 4'b0011);
        check("rst_stall_a", a_stall, 32'd0);
        check("rst_flush_a", a_flush, 32'd0);

        @(negedge clk); reset_n = 1'b1; #1;
        check_a("idle_a", 4'b1100);
        check_b("idle_b", 4'b1100);

        // Load-use on rs: one bubble in A, three in B.
        @(negedge clk); load_use(); #1;
        check_a("lu_a", 4'b0001);
        check_b("lu_b0", 4'b0001);
        @(negedge clk); idle(); #1;
        check_a("lu_a_done", 4'b1100);
        check("lu_stall_a", a_stall, pc(1));
        check_b("lu_b1", 4'b0001);
        @(negedge clk); #1;
        check_b("lu_b2", 4'b0001);
        @(negedge clk); #1;
        check_b("lu_b_done", 4'b1100);
        check("lu_stall_b", {30'd0, b_stall}, pc(3));

        // Register zero never stalls.
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
        check_a("r0_a", 4'b1100);
        check_b("r0_b", 4'b1100);

        // rt match only counts when ID actually reads rt.
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
        check_a("rt_unused_a", 4'b1100);
        id_uses_rt = 1'b1; #1;
        check_a("rt_used_a", 4'b0001);
        check_b("rt_used_b", 4'b0001);
        @(negedge clk); idle(); #1;
        check("rt_stall_a", a_stall, pc(2));
        check_b("rt_b1", 4'b0001);
        @(negedge clk); #1;
        check_b("rt_b2", 4'b0001);
        @(negedge clk); #1;
        check_b("rt_b_done", 4'b1100);
        check("sat_stall_b", {30'd0, b_stall}, pc(3));

        // Taken condition without a branch is ignored.
        @(negedge clk); idle(); ex_branch_taken = 1'b1; #1;
        check_a("nobr_a", 4'b1100);

        // Taken branch together with load-use: branch wins.
        @(negedge clk); load_use(); ex_branch = 1'b1; ex_branch_taken = 1'b1; #1;
        check_a("tkn_hzd_a", 4'b1111);
        check_b("tkn_hzd_b", 4'b1111);
        @(negedge clk); idle(); #1;
        check_a("tkn_a_done", 4'b1100);
        check("tkn_flush_a", a_flush, pc(1));
        check("tkn_stall_a", a_stall, pc(2));
        check_b("tkn_b1", 4'b1111);
        @(negedge clk); #1;
        check_b("tkn_b2", 4'b1111);
        @(negedge clk); #1;
        check_b("tkn_b_done", 4'b1100);
        check("tkn_flush_b", {30'd0, b_flush}, pc(1));

        // Reset asserted in the middle of B's stall sequence.
        @(negedge clk); load_use(); #1;
        check_b("mid_b0", 4'b0001);
        @(negedge clk); idle(); #1;
        check_b("mid_b1", 4'b0001);
        reset_n = 1'b0; #1;
        check_b("mid_rst_b", 4'b0011);
        check_a("mid_rst_a", 4'b0011);
        check("mid_rst_stall_b", {30'd0, b_stall}, 32'd0);
        check("mid_rst_flush_b", {30'd0, b_flush}, 32'd0);
        @(negedge clk); reset_n = 1'b1; #1;
        check_b("post_rst_b", 4'b1100);
        @(negedge clk); #1;
        check_b("post_rst_b2", 4'b1100);
        check("post_rst_stall_a", a_stall, 32'd0);
        check("post_rst_stall_b", {30'd0, b_stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
